uart_loader: RTL and testbench

Serial debug/boot bridge: consumes bytes from the `uart` byte interface, parses host commands, and acts as an initiator on the word-wide memory bus to load or inspect RAM while the core is held halted. It is the opposite end of the memory bus from the RAM responder in `top`. It sits beside `core` behind a bus mux selected by `halt`, and owns the serial byte stream while active.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/uart_loader.sv | 218 +++++++++++++++++++++
 tb/tb_uart_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared constants and FSM state encoding for the serial boot/debug loader.
package loader_pkg;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  localparam logic [1:0] MEM_SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DATA,
    S_MEM,
    S_RDWAIT,
    S_TX,
    S_TXGAP
  } loader_state_e;

endpackage

// File: rtl/uart_loader.sv
// Serial command parser that loads/inspects RAM as a word-wide bus initiator.
// Optional inter-byte abort timer is built when LOADER_TIMEOUT_EN is defined.
module uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_ready,
  input  logic [7:0]    rx_data,
  output logic          rx_rd,
  input  logic          tx_busy,
  output logic [7:0]    tx_data,
  output logic          tx_wr,
  output logic          mem_r,
  output logic          mem_w,
  output logic [1:0]    mem_sz,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_busy,
  output logic          halt,
  output loader_state_e dbg_state
);

  // Handshakes: a byte is taken when rx_ready=1 in a receiving state and
  // rx_rd pulses that cycle; the next cycle ignores rx_ready. A byte is sent
  // by pulsing tx_wr while tx_busy=0. A bus request is held until mem_busy=0.
  loader_state_e state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          is_w_q, is_w_d;
  logic          halt_q, halt_d;
  logic          tx_multi_q, tx_multi_d;
  logic          rx_hold_q;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   tx_sh_q, tx_sh_d;
  logic          rx_state;
  logic          rx_take;
  logic          timeout_hit;

  assign rx_state = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign rx_take  = !rst && rx_state && rx_ready && !rx_hold_q;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;

  assign idle_d      = rx_rd ? 32'd0 :
                       (idle_q != TIMEOUT_CYCLES) ? idle_q + 32'd1 : idle_q;
  assign timeout_hit = (idle_q == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CMD;
      cnt_q      <= '0;
      is_w_q     <= 1'b0;
      halt_q     <= 1'b1;
      tx_multi_q <= 1'b0;
      rx_hold_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      tx_sh_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_w_q     <= is_w_d;
      halt_q     <= halt_d;
      tx_multi_q <= tx_multi_d;
      rx_hold_q  <= rx_take;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_w_d     = is_w_q;
    halt_d     = halt_q;
    tx_multi_d = tx_multi_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tx_sh_d    = tx_sh_q;
    case (state_q)
      S_CMD: begin
        if (rx_take) begin
          cnt_d      = '0;
          tx_multi_d = 1'b0;
          case (rx_data)
            CMD_W, CMD_R: begin
              is_w_d  = (rx_data == CMD_W);
              state_d = S_ADDR;
            end
            CMD_H: begin
              halt_d  = 1'b1;
              tx_sh_d = {24'h0, ACK};
              state_d = S_TX;
            end
            CMD_G: begin
              halt_d  = 1'b0;
              tx_sh_d = {24'h0, ACK};
              state_d = S_TX;
            end
            default: begin
              tx_sh_d = {24'h0, NAK};
              state_d = S_TX;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (rx_take) begin
          addr_d = {rx_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_w_q) begin
              state_d = S_DATA;
            end else if (halt_q) begin
              state_d = S_MEM;
            end else begin
              tx_multi_d = 1'b0;
              tx_sh_d    = {24'h0, NAK};
              state_d    = S_TX;
            end
          end
        end else if (timeout_hit) begin
          state_d = S_CMD;
        end
      end
      S_DATA: begin
        if (rx_take) begin
          data_d = {rx_data, data_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (halt_q) begin
              state_d = S_MEM;
            end else begin
              tx_multi_d = 1'b0;
              tx_sh_d    = {24'h0, NAK};
              state_d    = S_TX;
            end
          end
        end else if (timeout_hit) begin
          state_d = S_CMD;
        end
      end
      S_MEM: begin
        if (!mem_busy) begin
          cnt_d = '0;
          if (is_w_q) begin
            tx_multi_d = 1'b0;
            tx_sh_d    = {24'h0, ACK};
            state_d    = S_TX;
          end else begin
            state_d = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        tx_multi_d = 1'b1;
        tx_sh_d    = mem_rdata;
        cnt_d      = '0;
        state_d    = S_TX;
      end
      S_TX: begin
        if (!tx_busy) begin
          tx_sh_d = {8'h0, tx_sh_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          state_d = S_TXGAP;
        end
      end
      S_TXGAP: begin
        // A 4-byte read reply wraps the counter back to 0 after its last byte.
        state_d = (tx_multi_q && cnt_q != 2'd0) ? S_TX : S_CMD;
      end
      default: state_d = S_CMD;
    endcase
  end

  always_comb begin
    rx_rd = 1'b0;
    tx_wr = 1'b0;
    mem_r = 1'b0;
    mem_w = 1'b0;
    if (!rst) begin
      case (state_q)
        S_CMD, S_ADDR, S_DATA: rx_rd = rx_take;
        S_MEM: begin
          mem_w = is_w_q;
          mem_r = !is_w_q;
        end
        S_TX:    tx_wr = !tx_busy;
        default: ;
      endcase
    end
  end

  assign tx_data   = tx_sh_q[7:0];
  assign mem_sz    = MEM_SZ_WORD;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = data_q;
  assign halt      = halt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: directed commands, expected bus and tx queues.
module tb_uart_loader;
  import loader_pkg::*;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TMO = 100;
`else
  localparam int unsigned TMO = 2700000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_rd;
  logic          tx_busy = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_wr;
  logic          mem_r, mem_w;
  logic [1:0]    mem_sz;
  logic [31:0]   mem_addr, mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          mem_busy = 1'b0;
  logic          halt;
  loader_state_e dbg_state;

  uart_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_rd     (rx_rd),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_sz    (mem_sz),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_busy  (mem_busy),
    .halt      (halt),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]  exp_tx_q[$];
  logic [64:0] exp_mem_q[$];
  logic [31:0] ram [logic [31:0]];

  int          cyc = 0;
  int          last_rd_cyc = 0;
  int          acc_cyc = 0;
  bit          acc_pending = 0;
  bit          acc_w = 0;
  bit          req_prev = 0;
  int          hold = 0;
  int          exp_hold = 1;
  int          stall_left = 0;
  int          busy_cnt = 0;
  bit          rd_pending = 0;
  logic [31:0] rd_val = 32'h0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [95:0] act);
    n_checks++;
    n_fails++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      #4;
      if (rx_rd === 1'b1) got = 1;
      @(posedge clk);
      if (!got) @(negedge clk);
    end
    #1 rx_ready = 1'b0;
    if (!got) unexpected("rx_byte_not_taken", b);
  endtask

  task automatic send_word(input logic [31:0] v);
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
  endtask

  task automatic send_w(input logic [31:0] a, input logic [31:0] d);
    send_byte(CMD_W);
    send_word(a);
    send_word(d);
  endtask

  task automatic send_r(input logic [31:0] a);
    send_byte(CMD_R);
    send_word(a);
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
    exp_mem_q.push_back({1'b1, a, d});
    exp_tx_q.push_back(8'h06);
  endtask

  task automatic exp_read(input logic [31:0] a, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    exp_mem_q.push_back({1'b0, a, 32'h0});
    exp_tx_q.push_back(b0);
    exp_tx_q.push_back(b1);
    exp_tx_q.push_back(b2);
    exp_tx_q.push_back(b3);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_tx_q.size() != 0 || exp_mem_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) unexpected("drain_timeout", exp_tx_q.size() + exp_mem_q.size());
    repeat (8) @(negedge clk);
  endtask

  // UART tx / RAM responder models and scoreboard monitor
  initial begin
    logic [64:0] e;
    logic [64:0] act;
    bit          req;
    forever begin
      @(negedge clk);
      tx_busy = (busy_cnt != 0);
      if (busy_cnt != 0) busy_cnt--;
      mem_busy  = (stall_left != 0);
      mem_rdata = rd_pending ? rd_val : $urandom();
      rd_pending = 0;
      #4;
      cyc++;
      if (rx_rd === 1'b1) last_rd_cyc = cyc;
      req = !rst && (mem_w === 1'b1 || mem_r === 1'b1);
      if (req) begin
        if (!req_prev) begin
          check("req_latency", cyc - last_rd_cyc, 1);
          hold = 0;
        end
        hold++;
        check("mem_sz", mem_sz, 2'd2);
        if (!mem_busy) begin
          act = {mem_w, mem_addr, (mem_w ? mem_wdata : 32'h0)};
          if (exp_mem_q.size() == 0) unexpected("mem_req", act);
          else begin
            e = exp_mem_q.pop_front();
            check("mem_req", act, e);
          end
          check("mem_hold", hold, exp_hold);
          exp_hold = 1;
          if (mem_w) ram[mem_addr] = mem_wdata;
          else begin
            rd_val     = ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
            rd_pending = 1;
          end
          acc_cyc     = cyc;
          acc_w       = mem_w;
          acc_pending = 1;
        end else if (stall_left > 0) begin
          stall_left--;
        end
      end
      req_prev = req;
      if (!rst && tx_wr === 1'b1) begin
        check("tx_wr_while_busy", tx_busy, 1'b0);
        if (acc_pending) begin
          check("tx_latency", cyc - acc_cyc, acc_w ? 1 : 2);
          acc_pending = 0;
        end
        if (exp_tx_q.size() == 0) unexpected("tx_byte", tx_data);
        else check("tx_byte", tx_data, exp_tx_q.pop_front());
        busy_cnt = 3;
      end
    end
  end

  initial begin
    #500000;
    unexpected("watchdog", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_halt", halt, 1'b1);
    check("rst_rx_rd", rx_rd, 1'b0);
    check("rst_tx_wr", tx_wr, 1'b0);
    check("rst_mem_rw", {mem_r, mem_w}, 2'b00);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_state", dbg_state, S_CMD);
    @(negedge clk);
    rst = 1'b0;

    exp_write(32'h100, 32'hDEADBEEF);
    send_w(32'h0000_0100, 32'hDEADBEEF);
    wait_drain();

    exp_read(32'h100, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_r(32'h0000_0100);
    wait_drain();

    stall_left = 3;
    exp_hold   = 4;
    exp_write(32'h104, 32'h12345678);
    send_w(32'h0000_0104, 32'h12345678);
    wait_drain();

    // low address bits are dropped on the bus
    exp_read(32'h104, 8'h78, 8'h56, 8'h34, 8'h12);
    send_r(32'h0000_0107);
    wait_drain();

    exp_tx_q.push_back(8'h06);
    send_byte(CMD_G);
    #1 check("halt_after_G", halt, 1'b0);
    wait_drain();
    exp_tx_q.push_back(8'h15);
    send_w(32'h0000_0100, 32'h11223344);
    wait_drain();
    exp_tx_q.push_back(8'h15);
    send_r(32'h0000_0100);
    wait_drain();
    exp_tx_q.push_back(8'h06);
    send_byte(CMD_H);
    #1 check("halt_after_H", halt, 1'b1);
    wait_drain();

    exp_tx_q.push_back(8'h15);
    exp_read(32'h100, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_byte(8'h5A);
    send_r(32'h0000_0100);
    wait_drain();

`ifdef LOADER_TIMEOUT_EN
    send_byte(CMD_W);
    send_byte(8'h00);
    send_byte(8'h01);
    repeat (150) @(negedge clk);
    exp_read(32'h100, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_r(32'h0000_0100);
    wait_drain();
`endif

    // reset while waiting for write data: nothing may come out
    send_byte(CMD_W);
    send_word(32'h0000_0100);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("state_after_midcmd_rst", dbg_state, S_CMD);
    repeat (20) @(negedge clk);
    exp_read(32'h100, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_r(32'h0000_0100);
    wait_drain();

    exp_tx_q.push_back(8'h06);
    send_byte(CMD_G);
    wait_drain();
    send_byte(CMD_W);
    send_word(32'h0000_0100);
    send_byte(8'h01);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("halt_after_rst", halt, 1'b1);
    repeat (20) @(negedge clk);

    check("tx_queue_empty", exp_tx_q.size(), 0);
    check("mem_queue_empty", exp_mem_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
